dcache_line_responder: RTL

DCACHE_LINE_RESPONDER -- requirements
Module: dcache_line_responder

---
 rtl/dcache_line_responder_pkg.sv | 35 +++
 rtl/dcache_line_responder_datapath.sv | 101 ++++++++++
 rtl/dcache_line_responder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dcache_line_responder_pkg.sv
// Shared types and constants for the single-line data cache responder.
//   state_e     : controller states (IDLE, HIT, WB, FILL, RESP)
//   LINE_W      : line width in bits (256)
//   BEAT_W      : memory beat width in bits (64)
//   TAG_W       : tag width in bits (27, address[31:5])
//   OFFSET_W    : byte offset width within a line (5)
//   merge_word  : byte-enable merge of a 32-bit store into an old word
package dcache_resp_types;

  localparam int LINE_W   = 256;
  localparam int BEAT_W   = 64;
  localparam int TAG_W    = 27;
  localparam int OFFSET_W = 5;
  localparam int WORD_W   = 32;

  typedef enum logic [2:0] {
    IDLE,
    HIT,
    WB,
    FILL,
    RESP
  } state_e;

  function automatic logic [WORD_W-1:0] merge_word(input logic [WORD_W-1:0] old_w,
                                                   input logic [WORD_W-1:0] new_w,
                                                   input logic [3:0]        mbe);
    logic [WORD_W-1:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (mbe[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_line_responder_datapath.sv
// Line storage for the responder: 256-bit line buffer, tag, valid and dirty
// bits, the 2-bit beat counter, the write-back beat mux, the fill beat demux
// and the store byte merge. All control comes from the FSM in the top.
//   clk, rst              : clock, asynchronous active-high reset
//   req_tag, word_sel     : address[31:5] and address[4:2] of the request
//   wdata, mbe            : store data and byte enables
//   pmem_rdata            : incoming fill beat
//   beat_adv              : advance the beat counter (one accepted beat)
//   fill_we               : write the current fill beat into the line
//   fill_done             : last fill beat; set valid, load tag, clear dirty
//   wb_done               : last write-back beat; clear dirty
//   store_we, set_dirty   : merge the store word, mark the line dirty
//   hit, dirty, last_beat : status back to the FSM
//   tag, rdata_word       : stored tag, selected load word
//   wb_beat               : line beat selected by the beat counter
module dcache_line_datapath
  import dcache_resp_types::*;
#(
  parameter int BURST_BEATS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [2:0]        word_sel,
  input  logic [WORD_W-1:0] wdata,
  input  logic [3:0]        mbe,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              beat_adv,
  input  logic              fill_we,
  input  logic              fill_done,
  input  logic              wb_done,
  input  logic              store_we,
  input  logic              set_dirty,
  output logic              hit,
  output logic              dirty,
  output logic              last_beat,
  output logic [TAG_W-1:0]  tag,
  output logic [WORD_W-1:0] rdata_word,
  output logic [BEAT_W-1:0] wb_beat
);

  logic [LINE_W-1:0] line_q, line_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              valid_q, valid_d;
  logic              dirty_q, dirty_d;
  logic [1:0]        beat_q, beat_d;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    line_d  = line_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    beat_d  = beat_q;

    if (fill_we)  line_d[{beat_q, 6'd0} +: BEAT_W] = pmem_rdata;
    if (store_we) line_d[{word_sel, 5'd0} +: WORD_W] =
                    merge_word(line_q[{word_sel, 5'd0} +: WORD_W], wdata, mbe);

    if (beat_adv) beat_d = beat_q + 2'd1;  // wraps to 0 after the last beat

    if (set_dirty) dirty_d = 1'b1;
    if (wb_done || fill_done) dirty_d = 1'b0;

    if (fill_done) begin
      valid_d = 1'b1;
      tag_d   = req_tag;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q   <= '0;
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
      beat_q  <= 2'd0;
    end else begin
      tag_q   <= tag_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      beat_q  <= beat_d;
    end
  end

  // NOTE: the line data itself has no reset; valid_q gates its use, and
  // leaving the wide array out of reset keeps it a plain register bank.
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  assign hit        = valid_q && (tag_q == req_tag);
  assign dirty      = dirty_q;
  assign tag        = tag_q;
  assign last_beat  = (beat_q == 2'(BURST_BEATS - 1));
  assign rdata_word = line_q[{word_sel, 5'd0} +: WORD_W];
  assign wb_beat    = line_q[{beat_q, 6'd0} +: BEAT_W];

endmodule

// File: rtl/dcache_line_responder.sv
// Single-line data cache responder: answers 32-bit CPU loads/stores from one
// 256-bit line and refills / writes back that line with 4-beat 64-bit bursts.
// Optional feature macro: DCACHE_LINE_WRITEBACK_EN
//   defined   : stores mark the line dirty; write-back only on eviction
//   undefined : write-through; every store writes the merged line back
//               before dcache_resp, dirty stays 0
// Ports:
//   clk, rst                        : clock, asynchronous active-high reset
//   dcache_read/write               : CPU request, held until dcache_resp
//   dcache_address/wdata/mbe        : byte address, store data, byte enables
//   dcache_resp, dcache_rdata       : completion pulse, load data
//   pmem_read/write, pmem_address   : burst request and line address
//   pmem_wdata, pmem_rdata          : write / read beat
//   pmem_resp                       : one pulse per beat
module dcache_line_responder
  import dcache_resp_types::*;
#(
  parameter int BURST_BEATS = 4  // only 4 is supported
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dcache_read,
  input  logic        dcache_write,
  input  logic [31:0] dcache_address,
  input  logic [31:0] dcache_wdata,
  input  logic [3:0]  dcache_mbe,
  output logic        dcache_resp,
  output logic [31:0] dcache_rdata,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [63:0] pmem_wdata,
  input  logic [63:0] pmem_rdata,
  input  logic        pmem_resp
);

  state_e state_q, state_d;
  logic   wr_q, wr_d;  // latched request type: 1 = store
  logic   wt_q, wt_d;  // write-through burst of the current store is done/underway

  logic              hit, dirty, last_beat;
  logic [TAG_W-1:0]  tag;
  logic [WORD_W-1:0] rdata_word;
  logic [BEAT_W-1:0] wb_beat;
  logic              beat_adv, fill_we, fill_done, wb_done, store_we, set_dirty;

  logic unused_addr_bits;
  assign unused_addr_bits = ^dcache_address[1:0];

  dcache_line_datapath #(
    .BURST_BEATS(BURST_BEATS)
  ) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .req_tag    (dcache_address[31:OFFSET_W]),
    .word_sel   (dcache_address[4:2]),
    .wdata      (dcache_wdata),
    .mbe        (dcache_mbe),
    .pmem_rdata (pmem_rdata),
    .beat_adv   (beat_adv),
    .fill_we    (fill_we),
    .fill_done  (fill_done),
    .wb_done    (wb_done),
    .store_we   (store_we),
    .set_dirty  (set_dirty),
    .hit        (hit),
    .dirty      (dirty),
    .last_beat  (last_beat),
    .tag        (tag),
    .rdata_word (rdata_word),
    .wb_beat    (wb_beat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      wt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      wt_q    <= wt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    wt_d        = wt_q;
    beat_adv    = 1'b0;
    fill_we     = 1'b0;
    fill_done   = 1'b0;
    wb_done     = 1'b0;
    store_we    = 1'b0;
    set_dirty   = 1'b0;
    dcache_resp = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;

    unique case (state_q)
      IDLE: begin
        wt_d = 1'b0;
        if (dcache_read || dcache_write) begin
          wr_d = dcache_write;  // read+write together is a store
          if (hit)        state_d = HIT;
          else if (dirty) state_d = WB;
          else            state_d = FILL;
        end
      end

      HIT, RESP: begin
`ifdef DCACHE_LINE_WRITEBACK_EN
        dcache_resp = 1'b1;
        store_we    = wr_q;
        set_dirty   = wr_q && (dcache_mbe != 4'd0);
        state_d     = IDLE;
`else
        // A store merges first, writes the line through, then returns here
        // with wt_q set to respond.
        if (wr_q && !wt_q) begin
          store_we = 1'b1;
          wt_d     = 1'b1;
          state_d  = WB;
        end else begin
          dcache_resp = 1'b1;
          state_d     = IDLE;
        end
`endif
      end

      WB: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          beat_adv = 1'b1;
          if (last_beat) begin
            wb_done = 1'b1;
            state_d = wt_q ? RESP : FILL;
          end
        end
      end

      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          beat_adv = 1'b1;
          fill_we  = 1'b1;
          if (last_beat) begin
            fill_done = 1'b1;
            state_d   = RESP;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pmem_address = 32'd0;
    pmem_wdata   = 64'd0;
    dcache_rdata = 32'd0;
    if (state_q == WB) begin
      pmem_address = {tag, 5'd0};
      pmem_wdata   = wb_beat;
    end
    if (state_q == FILL) pmem_address = {dcache_address[31:OFFSET_W], 5'd0};
    if (state_q == HIT || state_q == RESP) dcache_rdata = rdata_word;
  end

endmodule
